// File: rtl/arm_alu_writeback_pkg.sv
// Shared ARM definitions for the execute/writeback slice: opcodes, CPSR flag
// bit positions, condition codes and the pending register-file write record.
package arm_alu_writeback_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_RSC = 4'b0111;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_TEQ = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam int CPSR_N = 31;
   localparam int CPSR_Z = 30;
   localparam int CPSR_C = 29;
   localparam int CPSR_V = 28;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [3:0] REG_PC = 4'd15;

   typedef struct packed {
      logic        vld;
      logic [3:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   // TST/TEQ/CMP/CMN: always set flags, never write rd
   function automatic logic is_compare(input logic [3:0] op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluator; purely combinational so the branch unit can
// share it. The 4'b1111 encoding never passes.
module arm_cond_check
   import arm_alu_writeback_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_alu_writeback.sv
// Execute/writeback stage behind arm_alu: owns the CPSR flags, gates results on
// the condition field and holds a one-entry pending write to the RF or the PC.
module arm_alu_writeback
   import arm_alu_writeback_pkg::*;
#(
   parameter logic [31:0] CPSR_RESET = 32'h0000_00D3,
   parameter int          CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cond,
   input  logic [3:0]       in_opcode,
   input  logic             in_s,
   input  logic [3:0]       in_rd,
   input  logic [31:0]      alu_out,
   input  logic [31:0]      cpsr_next,
   output logic [31:0]      cpsr,
   output logic             rf_we,
   output logic [3:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   input  logic             wb_stall,
   output logic             pc_load,
   output logic [31:0]      pc_target,
   output logic [CNT_W-1:0] retired_count,
   output logic [CNT_W-1:0] skipped_count
);

   logic [3:0] flags;
   wb_req_t    pend;
   logic       pend_pc, pass, accept, retire, cmp;

   // Only NZCV is architectural state here; the low bits are fixed at reset value
   assign cpsr = {flags, CPSR_RESET[27:0]};

   arm_cond_check u_cond (
      .cond (in_cond),
      .nzcv (flags),
      .pass (pass)
   );

   assign cmp      = is_compare(in_opcode);
   assign pend_pc  = (pend.rd == REG_PC);
   // A PC load never waits on the register file
   assign in_ready = !(pend.vld && wb_stall && !pend_pc);
   assign accept   = in_valid && in_ready;
   assign retire   = pend.vld && (pend_pc || !wb_stall);

   assign rf_we     = pend.vld && !pend_pc;
   assign pc_load   = pend.vld && pend_pc;
   assign rf_waddr  = pend.rd;
   assign rf_wdata  = pend.data;
   assign pc_target = pend.data;

   always_ff @(posedge clk) begin
      if (reset) begin
         flags         <= CPSR_RESET[31:28];
         pend          <= '0;
         retired_count <= '0;
         skipped_count <= '0;
      end else begin
         if (accept && pass) begin
            retired_count <= retired_count + 1'b1;
            if (in_s || cmp)
               flags <= cpsr_next[CPSR_N:CPSR_V];
         end else if (accept) begin
            skipped_count <= skipped_count + 1'b1;
         end

         // A new write overwrites a retiring one on the same edge
         if (accept && pass && !cmp) begin
            pend.vld  <= 1'b1;
            pend.rd   <= in_rd;
            pend.data <= alu_out;
         end else if (retire) begin
            pend.vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arm_alu_writeback.sv
// Directed bench for arm_alu_writeback: ALU results and NZCV are hand-computed
// and driven directly in place of arm_alu.
module tb_arm_alu_writeback;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, in_s, wb_stall;
   logic [3:0]  in_cond, in_opcode, in_rd, rf_waddr;
   logic [31:0] alu_out, cpsr_next, cpsr, rf_wdata, pc_target;
   logic        rf_we, pc_load;
   logic [31:0] retired_count, skipped_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   arm_alu_writeback dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_cond       (in_cond),
      .in_opcode     (in_opcode),
      .in_s          (in_s),
      .in_rd         (in_rd),
      .alu_out       (alu_out),
      .cpsr_next     (cpsr_next),
      .cpsr          (cpsr),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .wb_stall      (wb_stall),
      .pc_load       (pc_load),
      .pc_target     (pc_target),
      .retired_count (retired_count),
      .skipped_count (skipped_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                        input logic [3:0] rd, input logic [31:0] res, input logic [3:0] nzcv);
      in_valid  = 1'b1;
      in_cond   = cond;
      in_opcode = op;
      in_s      = s;
      in_rd     = rd;
      alu_out   = res;
      cpsr_next = {nzcv, 28'h00000D3};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
      in_cond = 4'hE; in_opcode = 4'h0; in_s = 1'b0; in_rd = 4'h0;
      alu_out = '0; cpsr_next = '0;
      tick();
      reset = 1'b0;
      chk("rst_cpsr", cpsr, 32'h0000_00D3);
      chk("rst_we", rf_we, 0);
      chk("rst_pc", pc_load, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_ret", retired_count, 0);
      chk("rst_skp", skipped_count, 0);
      chk("rst_rdy", in_ready, 1);

      // ADD 32+96, S=1 -> 0x80, NZCV 0000
      issue(4'hE, 4'b0100, 1'b1, 4'd3, 32'h80, 4'b0000);
      tick(); in_valid = 1'b0;
      chk("add_we", rf_we, 1);
      chk("add_waddr", rf_waddr, 3);
      chk("add_wdata", rf_wdata, 32'h80);
      chk("add_cpsr", cpsr, 32'h0000_00D3);
      chk("add_ret", retired_count, 1);

      // SUB 32-96, S=1 -> 0xFFFFFFC0, N=1 C=0
      issue(4'hE, 4'b0010, 1'b1, 4'd4, 32'hFFFF_FFC0, 4'b1000);
      tick(); in_valid = 1'b0;
      chk("sub_waddr", rf_waddr, 4);
      chk("sub_wdata", rf_wdata, 32'hFFFF_FFC0);
      chk("sub_cpsr", cpsr, 32'h8000_00D3);

      // Fresh reset, then CMP / MOVMI / MOVEQ back-to-back
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2_cpsr", cpsr, 32'h0000_00D3);
      issue(4'hE, 4'b1010, 1'b0, 4'd0, 32'hFFFF_FFC0, 4'b1000);
      tick();
      chk("cmp_we", rf_we, 0);
      chk("cmp_cpsr", cpsr, 32'h8000_00D3);
      issue(4'b0100, 4'b1101, 1'b0, 4'd5, 32'h55, 4'b0000);
      tick();
      chk("mi_we", rf_we, 1);
      chk("mi_waddr", rf_waddr, 5);
      chk("mi_wdata", rf_wdata, 32'h55);
      issue(4'b0000, 4'b1101, 1'b0, 4'd6, 32'h66, 4'b0000);
      tick(); in_valid = 1'b0;
      chk("eq_we", rf_we, 0);
      chk("eq_cpsr", cpsr, 32'h8000_00D3);
      chk("seq_ret", retired_count, 2);
      chk("seq_skp", skipped_count, 1);

      // Stalled write to r7 with the next instruction held on the input
      issue(4'hE, 4'b0100, 1'b0, 4'd7, 32'h77, 4'b0000);
      tick();
      wb_stall = 1'b1;
      issue(4'hE, 4'b1101, 1'b0, 4'd8, 32'h88, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stl_rdy", in_ready, 0);
         chk("stl_we", rf_we, 1);
         chk("stl_waddr", rf_waddr, 7);
         chk("stl_wdata", rf_wdata, 32'h77);
         chk("stl_ret", retired_count, 3);
         tick();
      end
      wb_stall = 1'b0;
      #1;
      chk("rel_rdy", in_ready, 1);
      chk("rel_waddr", rf_waddr, 7);
      tick(); in_valid = 1'b0;
      chk("rel_we", rf_we, 1);
      chk("rel_waddr2", rf_waddr, 8);
      chk("rel_wdata2", rf_wdata, 32'h88);
      chk("rel_ret", retired_count, 4);
      tick();
      chk("rel_idle", rf_we, 0);

      // ORR into r15 -> one-cycle PC load, unaffected by wb_stall
      issue(4'hE, 4'b1100, 1'b0, 4'd15, 32'h100, 4'b0000);
      tick(); in_valid = 1'b0;
      wb_stall = 1'b1;
      #1;
      chk("pc_load", pc_load, 1);
      chk("pc_tgt", pc_target, 32'h100);
      chk("pc_we", rf_we, 0);
      chk("pc_rdy", in_ready, 1);
      tick();
      wb_stall = 1'b0;
      chk("pc_once", pc_load, 0);

      // Reset while a write is stalled and a flag-setting instruction waits
      issue(4'hE, 4'b0100, 1'b1, 4'd9, 32'h99, 4'b0110);
      tick();
      chk("pre_cpsr", cpsr, 32'h6000_00D3);
      chk("pre_ret", retired_count, 6);
      wb_stall = 1'b1;
      issue(4'hE, 4'b0100, 1'b1, 4'd10, 32'hAA, 4'b1111);
      reset = 1'b1;
      tick();
      chk("rr_we", rf_we, 0);
      chk("rr_cpsr", cpsr, 32'h0000_00D3);
      chk("rr_ret", retired_count, 0);
      chk("rr_skp", skipped_count, 0);
      // Accept during reset must not commit flags either
      wb_stall = 1'b0;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("rr2_cpsr", cpsr, 32'h0000_00D3);
      chk("rr2_we", rf_we, 0);

      // Never condition skips; GT passes with NZCV 0000
      issue(4'b1111, 4'b1101, 1'b0, 4'd1, 32'h11, 4'b0000);
      tick();
      chk("nv_we", rf_we, 0);
      chk("nv_skp", skipped_count, 1);
      issue(4'b1100, 4'b1101, 1'b0, 4'd2, 32'h22, 4'b0000);
      tick(); in_valid = 1'b0;
      chk("gt_we", rf_we, 1);
      chk("gt_waddr", rf_waddr, 2);
      chk("gt_ret", retired_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
